// File: rtl/dec_pkg.sv
// Shared widths and types for the register-bank destination decoder.
// Used by the register bank write path and reg_dest_decoder.
package dec_pkg;
  localparam int DEC_IN_W  = 4;
  localparam int DEC_OUT_W = 16;

  typedef logic [DEC_IN_W-1:0]  dest_idx_t;
  typedef logic [DEC_OUT_W-1:0] dest_sel_t;
endpackage

// File: rtl/dec_onehot_comb.sv
// Purely combinational IN_W-to-OUT_W one-hot decoder.
// Ports: idx (index in), sel (one-hot select out, sel[i] = idx==i).
module dec_onehot_comb
  import dec_pkg::*;
#(
  parameter int  IN_W  = DEC_IN_W,
  localparam int OUT_W = 2**IN_W
) (
  input  logic [IN_W-1:0]  idx,
  output logic [OUT_W-1:0] sel
);

  for (genvar i = 0; i < OUT_W; i++) begin : g_line
    assign sel[i] = (idx == IN_W'(i));
  end

endmodule

// File: rtl/reg_dest_decoder.sv
// Registered one-hot destination decoder with enable gating and valid.
// Ports: clk, rst (sync, active-high), en, in, out, valid, and
// onehot_err only when DEC_ONEHOT_CHECK_EN is defined.
module reg_dest_decoder
  import dec_pkg::*;
#(
  parameter int  IN_W  = DEC_IN_W,
  localparam int OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
`ifdef DEC_ONEHOT_CHECK_EN
  output logic             onehot_err,
`endif
  output logic             valid
);

  logic [OUT_W-1:0] dec;

  dec_onehot_comb #(
    .IN_W (IN_W)
  ) u_dec (
    .idx (in),
    .sel (dec)
  );

  // Registered so downstream write-enables never see decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      valid <= 1'b0;
    end else begin
      out   <= en ? dec : '0;
      valid <= en;
    end
  end

`ifdef DEC_ONEHOT_CHECK_EN
  logic multi;
  logic stray;
  logic bad;

  // x & (x-1) clears the lowest set bit; nonzero means 2+ bits set.
  assign multi = |(out & (out - OUT_W'(1)));
  assign stray = (|out) && !valid;
  assign bad   = multi || stray;

  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_err <= 1'b0;
    end else if (bad) begin
      onehot_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_dest_decoder.sv
// Bench for reg_dest_decoder: directed vectors, a 2**in model,
// a per-cycle compare process and literal pinning checks.
module tb_reg_dest_decoder;
  import dec_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      en  = 1'b1;
  dest_idx_t in  = 4'd5;
  dest_sel_t out;
  logic      valid;
`ifdef DEC_ONEHOT_CHECK_EN
  logic      onehot_err;
`endif

  int tests  = 0;
  int fails  = 0;
  bit started = 1'b0;
  bit chk_en  = 1'b1;

  dest_sel_t exp_out   = '0;
  logic      exp_valid = 1'b0;

  reg_dest_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in         (in),
    .out        (out),
`ifdef DEC_ONEHOT_CHECK_EN
    .onehot_err (onehot_err),
`endif
    .valid      (valid)
  );

  always #5 clk = ~clk;

  // Model: after an edge, out is 2**in when enabled and not in reset.
  always @(posedge clk) begin
    if (!rst && en) begin
      exp_out   = dest_sel_t'(2 ** int'(in));
      exp_valid = 1'b1;
    end else begin
      exp_out   = '0;
      exp_valid = 1'b0;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started && chk_en) begin
      tests++;
      if (out !== exp_out || valid !== exp_valid) begin
        fails++;
        $display("FAIL model: out=%h valid=%b want out=%h valid=%b",
                 out, valid, exp_out, exp_valid);
      end
      tests++;
      if (valid ? ($countones(out) != 1) : (out != '0)) begin
        fails++;
        $display("FAIL onehot: out=%h valid=%b", out, valid);
      end
`ifdef DEC_ONEHOT_CHECK_EN
      tests++;
      if (onehot_err !== 1'b0) begin
        fails++;
        $display("FAIL err_quiet: onehot_err=%b want 0", onehot_err);
      end
`endif
    end
  end

  task automatic cyc(input logic r, input logic e, input dest_idx_t i);
    @(negedge clk);
    rst = r;
    en  = e;
    in  = i;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input dest_sel_t o, input logic v);
    tests++;
    if (out !== o || valid !== v) begin
      fails++;
      $display("FAIL %s: out=%h valid=%b want out=%h valid=%b",
               nm, out, valid, o, v);
    end
  endtask

  initial begin
    cyc(1'b1, 1'b1, 4'd5);
    cyc(1'b1, 1'b1, 4'd5);
    lit("reset", 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 4'd5);
    lit("rel_in5", 16'h0020, 1'b1);

    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        cyc(1'b1, 1'b1, 4'd7);
        lit("mid_rst", 16'h0000, 1'b0);
      end else begin
        cyc(1'b0, 1'b1, dest_idx_t'(i));
      end
      if (i == 0) lit("sweep_0", 16'h0001, 1'b1);
      if (i == 8) lit("resume_8", 16'h0100, 1'b1);
      if (i == 15) lit("sweep_f", 16'h8000, 1'b1);
    end

    cyc(1'b0, 1'b0, 4'hA);
    lit("en_off", 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 4'hA);
    lit("en_on_a", 16'h0400, 1'b1);

    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1, (k % 2 == 0) ? 4'h0 : 4'hF);
      if (k % 2 == 0) lit("alt_0", 16'h0001, 1'b1);
      else            lit("alt_f", 16'h8000, 1'b1);
    end

`ifdef DEC_ONEHOT_CHECK_EN
    chk_en = 1'b0;
    @(negedge clk);
    force dut.out = 16'h0003;
    @(posedge clk);
    #1;
    release dut.out;
    cyc(1'b0, 1'b1, 4'd3);
    cyc(1'b0, 1'b1, 4'd4);
    tests++;
    if (onehot_err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: onehot_err=%b want 1", onehot_err);
    end
    lit("after_force", 16'h0010, 1'b1);
    cyc(1'b1, 1'b0, 4'd0);
    tests++;
    if (onehot_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clr: onehot_err=%b want 0", onehot_err);
    end
`endif

    cyc(1'b0, 1'b0, 4'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_dest_decoder.md
Name: reg_dest_decoder

Overview:
- Registered 4-to-16 one-hot destination decoder for the register bank write path.
- Converts a 4-bit destination register index into a 16-bit one-hot select vector, one line per register.
- The select vector is gated by a write enable and registered on the clock, so downstream register write-enables are glitch-free.
- Width is parameterised; the default instance is 4-to-16.

Parameters:
- IN_W, 4, width of the destination index.
- OUT_W, 2**IN_W (16), width of the one-hot output; derived, must not be overridden independently.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  decode enable (register-bank write enable)
- in  input  IN_W  destination register index
- out  output  OUT_W  registered one-hot select
- valid  output  1  registered copy of en; high when out holds a decoded select
- onehot_err  output  1  only present when DEC_ONEHOT_CHECK_EN is defined; see Optional Feature

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset: on a clk edge with rst=1, out=0 and valid=0; onehot_err=0 if present. Reset has priority over en.
- Latency is 1 cycle. At a clk edge with rst=0:
  - out[i] <= (en && in==i) for every i in 0..OUT_W-1.
  - valid <= en.
- en=0 at an edge: out <= 0 and valid <= 0. The output does not hold its previous value.
- Exactly one bit of out is high whenever valid=1; out is all-zero whenever valid=0.
- Numeric value of out when valid=1 is 2**in:
  - in=0 gives 1.
  - in=0xF gives 32768 (0x8000).
- Each cycle is independent; there is no wrap-around or state beyond the output register.
- Back-to-back index changes every cycle are fully supported; out tracks in with 1-cycle delay.
- Unknown (X) bits on in while en=1 may produce X on out. No X-masking is required.
- Reset asserted mid-stream clears out on that same edge, regardless of in or en.
- No combinational path from any input to out or valid.

Optional Feature:
- Macro: DEC_ONEHOT_CHECK_EN.
- When defined:
  - Adds output onehot_err and an internal checker on the registered out.
  - onehot_err is sticky. It is set on the edge after out is observed to be neither all-zero nor exactly one-hot, or after out is nonzero while valid=0.
  - onehot_err clears only on rst.
  - Used for fault-injection checks.
- When undefined: the port and all checker logic are absent. Functional behaviour of out and valid is identical.

Decomposition:
- Shared package dec_pkg:
  - localparam DEC_IN_W = 4 and DEC_OUT_W = 16.
  - typedef dest_idx_t (logic [3:0]) and typedef dest_sel_t (logic [15:0]).
  - Used by the register bank and the decoder.
- One natural sub-module: dec_onehot_comb, the purely combinational IN_W-to-OUT_W decoder, built with a generate loop.
- The top-level reg_dest_decoder adds the enable gating, output register, valid flag and the optional checker.

Test Plan:
- Reset: hold rst=1 for 2 cycles with en=1, in=5 -> out=0, valid=0. Release rst -> next edge gives out=0x0020, valid=1.
- Full sweep: en=1, in=0..15 one per cycle -> out one cycle later equals 1, 2, 4, ... 32768. Scoreboard checks out==1<<in_prev and $countones(out)==1.
- Enable gating: en=0 with in=0xA -> out=0, valid=0. Then en=1 -> next cycle out=0x0400.
- Back-to-back and endpoints: in alternates 0x0/0xF each cycle with en=1 -> out alternates 0x0001/0x8000 with 1-cycle lag.
- Reset mid-stream: during the sweep at in=7, assert rst for one cycle -> out=0 on that edge. Decoding resumes on the following edge.
- With DEC_ONEHOT_CHECK_EN: force out to 0x0003 for one cycle -> onehot_err=1 and stays 1 after the force is released, until rst. In normal operation onehot_err stays 0 across the full sweep.
